// File: rtl/fir_decim_out_buffer.sv
// FIR decimator, descaler and FWFT output FIFO with sticky overflow flag.
// Define FIR_DEC_ROUND_EN for round-half-up descaling (default truncates).
module fir_decim_out_buffer #(
  parameter int N           = 16,
  parameter int DECIM       = 4,
  parameter int SCALE_SHIFT = 7,
  parameter int DEPTH       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [N-1:0]           in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  input  logic                   clear_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0] LAST = PW'(DECIM - 1);

  logic [PW-1:0] phase;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [N-1:0]  mem [DEPTH];
  logic [N-1:0]  scaled;
  logic          keep;
  logic          full;
  logic          push;
  logic          pop;

`ifdef FIR_DEC_ROUND_EN
  localparam int RS = (SCALE_SHIFT > 0) ? SCALE_SHIFT - 1 : 0;
  localparam logic [N:0] RND =
    (SCALE_SHIFT > 0) ? ((N+1)'(1) << RS) : '0;
  logic [N:0] sum;
  // One extra bit so the rounding add can never wrap.
  assign sum    = {1'b0, in_data} + RND;
  assign scaled = N'(sum >> SCALE_SHIFT);
`else
  assign scaled = in_data >> SCALE_SHIFT;
`endif

  assign keep      = in_valid && (phase == LAST);
  assign full      = (fifo_count == CW'(DEPTH));
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = keep && (!full || pop);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (in_valid) begin
      phase <= (phase == LAST) ? '0 : phase + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= scaled;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case (1'b1)
        (push && !pop): fifo_count <= fifo_count + CW'(1);
        (pop && !push): fifo_count <= fifo_count - CW'(1);
        default:        fifo_count <= fifo_count;
      endcase
    end
  end

  // A dropped keep takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (keep && !push) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_decim_out_buffer.sv
// Directed bench for fir_decim_out_buffer with default parameters.
// Expected values are hand-computed for truncate and round builds.
module tb_fir_decim_out_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        clear_ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp_t;
    logic [15:0] exp_r;
  } vec_t;

  vec_t vt [9];

  fir_decim_out_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: act=%0h req=%0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_data  = 16'h0;
  endtask

  task automatic kept(input logic [15:0] d);
    repeat (3) sample(16'h0);
    sample(d);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  function automatic logic [15:0] pick(input int i);
`ifdef FIR_DEC_ROUND_EN
    return vt[i].exp_r;
`else
    return vt[i].exp_t;
`endif
  endfunction

  initial begin
    vt[0] = '{16'h1000, 16'h0020, 16'h0020};
    vt[1] = '{16'h00C0, 16'h0001, 16'h0002};
    vt[2] = '{16'hFFFF, 16'h01FF, 16'h0200};
    vt[3] = '{16'h0000, 16'h0000, 16'h0000};
    vt[4] = '{16'h007F, 16'h0000, 16'h0001};
    vt[5] = '{16'h0080, 16'h0001, 16'h0001};
    vt[6] = '{16'h003F, 16'h0000, 16'h0000};
    vt[7] = '{16'h0040, 16'h0000, 16'h0001};
    vt[8] = '{16'h8000, 16'h0100, 16'h0100};

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      in_valid  = 1'($urandom);
      in_data   = 16'($urandom);
      out_ready = 1'($urandom);
      clear_ovf = 1'($urandom);
      step();
    end
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    reset     = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      sample(16'(k * 128));
      chk("rst_first_early", 32'(out_valid), 0);
    end
    sample(16'(4 * 128));
    chk("rst_first_valid", 32'(out_valid), 1);
    chk("rst_first_data", 32'(out_data), 4);

    // Empty with out_ready: nothing to pop
    do_reset();
    out_ready = 1'b1;
    repeat (3) step();
    chk("empty_ready_cnt", 32'(fifo_count), 0);
    chk("empty_ready_vld", 32'(out_valid), 0);

    // Steady stream
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h1000;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("stream_valid", 32'(out_valid), 32'((i % 4) == 3));
      if ((i % 4) == 3) chk("stream_data", 32'(out_data), 32'h20);
    end
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b0;

    // Scaling table
    do_reset();
    for (int i = 0; i < 9; i++) begin
      kept(vt[i].din);
      chk("scale_valid", 32'(out_valid), 1);
      chk("scale_data", 32'(out_data), 32'(pick(i)));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("scale_popped", 32'(fifo_count), 0);
    end

    // Overflow and clear
    do_reset();
    for (int k = 1; k <= 8; k++) kept(16'(k * 128));
    chk("ovf_full_cnt", 32'(fifo_count), 8);
    chk("ovf_not_yet", 32'(overflow), 0);
    kept(16'(9 * 128));
    chk("ovf_cnt", 32'(fifo_count), 8);
    chk("ovf_set", 32'(overflow), 1);
    repeat (3) step();
    chk("ovf_hold_data", 32'(out_data), 1);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    chk("ovf_clear", 32'(overflow), 0);
    repeat (3) sample(16'h0);
    clear_ovf = 1'b1;
    sample(16'(10 * 128));
    clear_ovf = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 1);
    chk("ovf_cnt2", 32'(fifo_count), 8);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    chk("ovf_clear2", 32'(overflow), 0);
    for (int k = 1; k <= 8; k++) begin
      chk("ovf_drain_vld", 32'(out_valid), 1);
      chk("ovf_drain_data", 32'(out_data), 32'(k));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    chk("ovf_drained_cnt", 32'(fifo_count), 0);
    chk("ovf_drained_vld", 32'(out_valid), 0);

    // Full with simultaneous push and pop
    do_reset();
    for (int k = 1; k <= 8; k++) kept(16'(k * 128));
    repeat (3) sample(16'h0);
    out_ready = 1'b1;
    sample(16'(9 * 128));
    out_ready = 1'b0;
    chk("pp_cnt", 32'(fifo_count), 8);
    chk("pp_ovf", 32'(overflow), 0);
    for (int k = 2; k <= 9; k++) begin
      chk("pp_drain_data", 32'(out_data), 32'(k));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    chk("pp_drained_cnt", 32'(fifo_count), 0);

    // Mid-run asynchronous reset
    do_reset();
    for (int k = 1; k <= 5; k++) kept(16'(k * 128));
    chk("mid_cnt5", 32'(fifo_count), 5);
    in_valid = 1'b1;
    in_data  = 16'h0100;
    #3;
    reset = 1'b0;
    #1;
    chk("mid_vld_async", 32'(out_valid), 0);
    chk("mid_cnt_async", 32'(fifo_count), 0);
    chk("mid_data_async", 32'(out_data), 0);
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample(16'h0100);
      chk("mid_phase_early", 32'(out_valid), 0);
    end
    sample(16'h0280);
    chk("mid_phase_vld", 32'(out_valid), 1);
    chk("mid_phase_data", 32'(out_data), 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
